// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-way set-associative, write-back,
// write-allocate cache. Owns tag/valid/dirty/LRU state, drives an external
// data array, and moves lines to/from backing memory over a req/ack handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata    CPU request; accepted when cpu_req & cpu_ready
//   cpu_ready                high only while idle
//   cpu_done, cpu_rdata      one-cycle completion pulse, read data (held)
//   da_set/way/we/wdata      data array control; da_rdata is its comb. read
//   mem_req/we/addr/wdata    memory request (we=1 write-back, we=0 refill)
//   mem_rdata, mem_ack       refill data, one-cycle completion
//   read_hit ... write_miss  saturating statistics counters
module cache_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 3,
    parameter int WAYS    = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ready,
    output logic               cpu_done,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic [INDEX_W-1:0] da_set,
    output logic [1:0]         da_way,
    output logic               da_we,
    output logic [DATA_W-1:0]  da_wdata,
    input  logic [DATA_W-1:0]  da_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [CNT_W-1:0]   read_hit,
    output logic [CNT_W-1:0]   read_miss,
    output logic [CNT_W-1:0]   write_hit,
    output logic [CNT_W-1:0]   write_miss
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]           addr_q;
    logic                        we_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [1:0]                  victim_q;
    logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0]             dirty_q [SETS];
    logic [WAYS-1:0][1:0]        age_q   [SETS];
    logic [DATA_W-1:0]           rdata_q;
    logic                        done_q;
    logic [CNT_W-1:0]            rd_hit_q, rd_miss_q, wr_hit_q, wr_miss_q;

    logic [INDEX_W-1:0]          set_idx;
    logic [TAG_W-1:0]            tag_in;
    logic                        hit;
    logic [1:0]                  hit_way;
    logic [1:0]                  victim_way;
    logic                        free_found;
    logic [1:0]                  lru_way;
    logic [WAYS-1:0][1:0]        age_upd;

    assign set_idx = addr_q[INDEX_W-1:0];
    assign tag_in  = addr_q[ADDR_W-1:INDEX_W];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Tag compare across the ways of the latched set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the oldest (age 3).
    always_comb begin
        victim_way = '0;
        free_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!free_found && !valid_q[set_idx][w]) begin
                victim_way = 2'(w);
                free_found = 1'b1;
            end
        end
        if (!free_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[set_idx][w] == 2'd3) begin
                    victim_way = 2'(w);
                end
            end
        end
    end

    // Ages after touching lru_way: younger ways age by one, touched way becomes 0.
    always_comb begin
        lru_way = (state_q == S_LOOKUP) ? hit_way : victim_q;
        age_upd = age_q[set_idx];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[set_idx][w] < age_q[set_idx][lru_way]) begin
                age_upd[w] = age_q[set_idx][w] + 2'd1;
            end
        end
        age_upd[lru_way] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        da_way    = victim_q;
        da_we     = 1'b0;
        da_wdata  = wdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = da_rdata;
        case (state_q)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    da_way  = hit_way;
                    da_we   = we_q;
                    state_d = S_IDLE;
                end else if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {tag_q[set_idx][victim_q], set_idx};
                if (mem_ack) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    da_we    = 1'b1;
                    da_wdata = we_q ? wdata_q : mem_rdata;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            victim_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            rd_hit_q  <= '0;
            rd_miss_q <= '0;
            wr_hit_q  <= '0;
            wr_miss_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                tag_q[s]   <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= 2'(w);
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        done_q         <= 1'b1;
                        age_q[set_idx] <= age_upd;
                        if (we_q) begin
                            dirty_q[set_idx][hit_way] <= 1'b1;
                            wr_hit_q <= sat_inc(wr_hit_q);
                        end else begin
                            rdata_q  <= da_rdata;
                            rd_hit_q <= sat_inc(rd_hit_q);
                        end
                    end else begin
                        victim_q <= victim_way;
                        if (we_q) begin
                            wr_miss_q <= sat_inc(wr_miss_q);
                        end else begin
                            rd_miss_q <= sat_inc(rd_miss_q);
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        done_q                     <= 1'b1;
                        age_q[set_idx]             <= age_upd;
                        valid_q[set_idx][victim_q] <= 1'b1;
                        tag_q[set_idx][victim_q]   <= tag_in;
                        dirty_q[set_idx][victim_q] <= we_q;
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign da_set     = set_idx;
    assign cpu_done   = done_q;
    assign cpu_rdata  = rdata_q;
    assign read_hit   = rd_hit_q;
    assign read_miss  = rd_miss_q;
    assign write_hit  = wr_hit_q;
    assign write_miss = wr_miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scenarios followed by randomized accesses against a
// reference model (flat golden memory plus per-set residency with use
// timestamps). The bench also plays the data array and the backing memory.
module tb_cache_ctrl;
    localparam int ADDR_W = 12, DATA_W = 32, INDEX_W = 3, CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0]       cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic              cpu_ready, cpu_done;
    logic [31:0]       cpu_rdata;
    logic [2:0]        da_set;
    logic [1:0]        da_way;
    logic              da_we;
    logic [31:0]       da_wdata, da_rdata;
    logic              mem_req, mem_we;
    logic [11:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [15:0]       read_hit, read_miss, write_hit, write_miss;

    cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .WAYS(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .da_set(da_set), .da_way(da_way), .da_we(da_we), .da_wdata(da_wdata), .da_rdata(da_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .read_hit(read_hit), .read_miss(read_miss), .write_hit(write_hit), .write_miss(write_miss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- environment: data array ----------------
    typedef struct { bit we; logic [11:0] addr; logic [31:0] data; } mem_ev_t;
    typedef struct { logic [2:0] set; logic [1:0] way; logic [31:0] data; } da_ev_t;
    mem_ev_t mem_log[$];
    da_ev_t  da_log[$];
    mem_ev_t mev;
    da_ev_t  dev;

    logic [31:0] darr [8][4];
    assign da_rdata = darr[da_set][da_way];

    always @(posedge clk) begin
        if (da_we === 1'b1) begin
            darr[da_set][da_way] <= da_wdata;
            dev.set  = da_set;
            dev.way  = da_way;
            dev.data = da_wdata;
            da_log.push_back(dev);
        end
    end

    // ---------------- environment: backing memory ----------------
    logic [31:0] mem [4096];
    int  delay = 0;
    bit  ack_always = 1'b0;
    int  wcnt = 0;
    bit  fire;

    always @(negedge clk) begin
        if (rst) begin
            wcnt    = 0;
            mem_ack = ack_always;
        end else begin
            if (mem_ack) wcnt = 0;
            fire = ack_always || ((mem_req === 1'b1) && (wcnt >= delay));
            if ((mem_req === 1'b1) && !fire) wcnt++;
            if ((mem_req === 1'b1) && fire) begin
                mev.we   = mem_we;
                mev.addr = mem_addr;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    mev.data      = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                    mev.data  = mem[mem_addr];
                end
                mem_log.push_back(mev);
            end
            mem_ack = fire;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] golden [4096];
    bit          mv [8][4];
    bit          md [8][4];
    logic [8:0]  mt [8][4];
    int          stamp [8][4];
    int          tnow;
    int          m_rhit, m_rmiss, m_whit, m_wmiss;

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                mt[s][w] = '0;
                stamp[s][w] = -1 - w;  // way 0 most recently used
            end
        end
        tnow = 0;
        m_rhit = 0; m_rmiss = 0; m_whit = 0; m_wmiss = 0;
        for (int i = 0; i < 4096; i++) golden[i] = mem[i];
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_ready"}, cpu_ready, 1);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_da_we"}, da_we, 0);
        chk({tag, "_done"}, cpu_done, 0);
        chk({tag, "_rdata"}, cpu_rdata, 0);
        chk({tag, "_cnt_rh"}, read_hit, 0);
        chk({tag, "_cnt_rm"}, read_miss, 0);
        chk({tag, "_cnt_wh"}, write_hit, 0);
        chk({tag, "_cnt_wm"}, write_miss, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One CPU access, checked against the model. Must be entered right after a negedge.
    task automatic access(input bit we, input logic [11:0] a, input logic [31:0] wd,
                          output int way, output bit obs_miss);
        int s, hw, nmem, cyc, exp_lat, d, exp_da;
        logic [8:0] t;
        bit wb, done;
        logic [11:0] wb_addr;
        s  = int'(a[2:0]);
        t  = a[11:3];
        hw = -1;
        wb = 1'b0;
        wb_addr = '0;
        for (int w = 0; w < 4; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        if (hw >= 0) begin
            way  = hw;
            nmem = 0;
        end else begin
            way = -1;
            for (int w = 0; w < 4; w++) if (way < 0 && !mv[s][w]) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < 4; w++) if (stamp[s][w] < stamp[s][way]) way = w;
            end
            wb      = mv[s][way] && md[s][way];
            wb_addr = {mt[s][way], a[2:0]};
            nmem    = wb ? 2 : 1;
        end
        d       = ack_always ? 0 : delay;
        exp_lat = 2 + nmem * (d + 1);
        exp_da  = (we || hw < 0) ? 1 : 0;

        mem_log.delete();
        da_log.delete();
        cyc = 0;
        while (cpu_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before_req", cpu_ready, 1);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'($urandom); cpu_wdata = $urandom;
        cyc  = 1;
        done = (cpu_done === 1'b1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            done = (cpu_done === 1'b1);
        end
        chk("done_seen", done, 1);
        chk("latency", cyc, exp_lat);
        if (!we) chk("rdata", cpu_rdata, golden[a]);
        chk("mem_txn_count", mem_log.size(), nmem);
        if (mem_log.size() == nmem && nmem > 0) begin
            if (wb) begin
                chk("wb_we", mem_log[0].we, 1);
                chk("wb_addr", mem_log[0].addr, wb_addr);
                chk("wb_data", mem_log[0].data, golden[wb_addr]);
            end
            chk("refill_we", mem_log[nmem-1].we, 0);
            chk("refill_addr", mem_log[nmem-1].addr, a);
        end
        chk("da_write_count", da_log.size(), exp_da);
        if (exp_da == 1 && da_log.size() == 1) begin
            chk("da_set", da_log[0].set, a[2:0]);
            chk("da_way", da_log[0].way, way);
            chk("da_wdata", da_log[0].data, we ? wd : golden[a]);
        end
        obs_miss = (mem_log.size() != 0);

        if (we) golden[a] = wd;
        if (hw < 0) begin
            mv[s][way] = 1'b1;
            mt[s][way] = t;
            md[s][way] = we;
            if (we) m_wmiss++; else m_rmiss++;
        end else begin
            if (we) begin md[s][way] = 1'b1; m_whit++; end
            else m_rhit++;
        end
        tnow++;
        stamp[s][way] = tnow;
        chk("cnt_read_hit", read_hit, sat(m_rhit));
        chk("cnt_read_miss", read_miss, sat(m_rmiss));
        chk("cnt_write_hit", write_hit, sat(m_whit));
        chk("cnt_write_miss", write_miss, sat(m_wmiss));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int way, cyc;
        bit miss;
        logic [31:0] wdat [4];
        logic [11:0] s4addr [4];

        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[12'h0A5] = 32'hDEADBEEF;

        // Scenario 1: cold read miss then hit
        do_reset("reset0");
        delay = 3;
        access(1'b0, 12'h0A5, '0, way, miss);
        chk("s1_miss", miss, 1);
        chk("s1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("s1_read_miss", read_miss, 1);
        access(1'b0, 12'h0A5, '0, way, miss);
        chk("s1_hit", miss, 0);
        chk("s1_read_hit", read_hit, 1);

        // Scenario 2: write hit then read back
        access(1'b1, 12'h0A5, 32'h12345678, way, miss);
        chk("s2_write_hit", write_hit, 1);
        chk("s2_way", way, 0);
        access(1'b0, 12'h0A5, '0, way, miss);
        chk("s2_readback", cpu_rdata, 32'h12345678);

        // Scenario 3: fill all ways of set 5, LRU eviction
        do_reset("reset3");
        delay = 1;
        s4addr[0] = 12'h005; s4addr[1] = 12'h00D; s4addr[2] = 12'h015; s4addr[3] = 12'h01D;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, s4addr[i], '0, way, miss);
            chk("s3_fill_way", way, i);
        end
        access(1'b0, 12'h005, '0, way, miss);
        chk("s3_rehit", miss, 0);
        access(1'b0, 12'h025, '0, way, miss);
        chk("s3_victim_way", way, 1);
        access(1'b0, 12'h00D, '0, way, miss);
        chk("s3_evicted_misses", miss, 1);

        // Scenario 4: dirty eviction via write-back
        do_reset("reset4");
        delay = 2;
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hA0000000 | 32'(i * 17 + 1);
            access(1'b1, s4addr[i], wdat[i], way, miss);
        end
        access(1'b0, 12'h025, '0, way, miss);
        if (mem_log.size() >= 2) begin
            chk("s4_wb_we", mem_log[0].we, 1);
            chk("s4_wb_addr", mem_log[0].addr, 12'h005);
            chk("s4_wb_data", mem_log[0].data, wdat[0]);
            chk("s4_refill_addr", mem_log[1].addr, 12'h025);
        end
        chk("s4_write_miss", write_miss, 4);
        chk("s4_read_miss", read_miss, 1);

        // Scenario 5: ack held high -> single-cycle memory states
        ack_always = 1'b1;
        access(1'b1, 12'h035, 32'h5555AAAA, way, miss);
        access(1'b0, 12'h0A5, '0, way, miss);
        access(1'b0, 12'h035, '0, way, miss);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s5_idle_ready", cpu_ready, 1);
            chk("s5_idle_mem_req", mem_req, 0);
        end
        chk("s5_idle_no_txn", mem_log.size(), 0);
        chk("s5_idle_rh", read_hit, sat(m_rhit));
        ack_always = 1'b0;

        // Scenario 6: reset in the middle of a refill
        do_reset("reset6a");
        delay = 1;
        access(1'b0, 12'h0A5, '0, way, miss);
        access(1'b0, 12'h0A5, '0, way, miss);
        chk("s6_prehit", miss, 0);
        delay = 8;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0B5;
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("s6_in_refill", mem_req, 1);
        do_reset("s6_midreset");
        delay = 0;
        access(1'b0, 12'h0A5, '0, way, miss);
        chk("s6_after_reset_miss", miss, 1);

        // Randomized accesses against the model
        for (int n = 0; n < 300; n++) begin
            logic [11:0] ra;
            bit rwe;
            ra[11:3]   = 9'($urandom_range(0, 5));
            ra[2:0]    = 3'($urandom_range(0, 7));
            rwe        = ($urandom_range(0, 1) == 1);
            delay      = $urandom_range(0, 3);
            ack_always = ($urandom_range(0, 9) == 0);
            access(rwe, ra, $urandom, way, miss);
        end
        ack_always = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
